// File: rtl/lwb_pkg.sv
// lwb_pkg: shared constants and elaboration helpers for line_window_buffer.
// The optional top-edge zero padding is selected with LWB_ZERO_PAD_EN
// in the top module; nothing in this package depends on it.
package lwb_pkg;

  // Legal window heights (K).
  localparam int LWB_MIN_LINES = 32'sd2;
  localparam int LWB_MAX_LINES = 32'sd16;

  // Ceiling log2, with lwb_clog2(1) == 0.
  function automatic int lwb_clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v      = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v      = v >>> 32'sd1;
    end
    return result;
  endfunction

  // Bank feeding output lane 'lane' when 'base' is the oldest line.
  function automatic int lwb_rot_idx(input int base, input int lane, input int num_banks);
    return (base + lane) % num_banks;
  endfunction

  // A width of 0, or one wider than a bank, means a full bank-width line.
  function automatic int lwb_clamp_width(input int width, input int max_width);
    if ((width == 32'sd0) || (width > max_width)) begin
      return max_width;
    end else begin
      return width;
    end
  endfunction

endpackage

// File: rtl/lwb_bank.sv
// lwb_bank: one line store. Simple dual-port RAM with a registered,
// read-first output. A read and a write to the same address in the same
// cycle return the previous contents.
module lwb_bank
  import lwb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port; the array is deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port; the register holds its value while not enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/line_window_buffer.sv
// line_window_buffer: streaming K-line window buffer. Each accepted pixel
// reads the K-1 stored lines at its column and emits one vertical column
// (oldest row in lane 0, live pixel in lane K-1) one cycle later.
// Optional macro LWB_ZERO_PAD_EN: emit priming beats with the missing
// upper rows forced to zero (top-edge padding).
module line_window_buffer
  import lwb_pkg::*;
#(
  parameter int NUM_LINES  = 3,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH:0]             img_width,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            s_sof,
  input  logic [DATA_WIDTH-1:0]           s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [NUM_LINES*DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0]           m_col,
  output logic                            m_eol
);

  localparam int NUM_BANKS   = NUM_LINES - 1;
  localparam int LINE_W      = (NUM_BANKS > 1) ? lwb_clog2(NUM_BANKS) : 1;
  localparam int FILL_W      = lwb_clog2(NUM_LINES);
  localparam int WID_W       = ADDR_WIDTH + 1;
  localparam int MAX_WIDTH_I = 2**ADDR_WIDTH;
  localparam logic [WID_W-1:0]  MAX_WIDTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_BANKS - 1);
  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(NUM_BANKS);

  if ((NUM_LINES < LWB_MIN_LINES) || (NUM_LINES > LWB_MAX_LINES)) begin : g_bad_lines
    $error("line_window_buffer: NUM_LINES outside 2..16");
  end

  // Input-side state
  logic [ADDR_WIDTH-1:0] r_wr_col;
  logic [LINE_W-1:0]     r_wr_line;
  logic [FILL_W-1:0]     r_lines_filled;
  logic [WID_W-1:0]      r_width;
  logic                  r_rst_d;

  // Output register
  logic                  r_m_valid;
  logic [ADDR_WIDTH-1:0] r_m_col;
  logic                  r_m_eol;
  logic [DATA_WIDTH-1:0] r_s_data;
  logic [LINE_W-1:0]     r_lane_base;
  logic [FILL_W-1:0]     r_pad;

  // Combinational
  logic                  w_acc;
  logic                  w_sof_acc;
  logic                  w_eol;
  logic                  w_emit;
  logic [WID_W-1:0]      w_width_clamp;
  logic [WID_W-1:0]      w_width_eff;
  logic [ADDR_WIDTH-1:0] w_col_eff;
  logic [ADDR_WIDTH-1:0] w_col_nxt;
  logic [LINE_W-1:0]     w_line_eff;
  logic [LINE_W-1:0]     w_line_nxt;
  logic [FILL_W-1:0]     w_fill_eff;
  logic [FILL_W-1:0]     w_fill_nxt;
  logic [FILL_W-1:0]     w_pad;
  logic [DATA_WIDTH-1:0] w_bank_rd [NUM_BANKS];
  logic [NUM_LINES*DATA_WIDTH-1:0] w_m_data;

  // Single output register without skid: accept only when it can be freed
  assign s_ready   = !reset && (!r_m_valid || m_ready);
  assign w_acc     = s_valid && s_ready;
  assign w_sof_acc = w_acc && s_sof;

  // Effective position of the accepted pixel (s_sof restarts the frame)
  // and the counter values that follow it
  always_comb begin
    w_width_clamp = WID_W'(lwb_clamp_width(int'(img_width), MAX_WIDTH_I));
    if (w_sof_acc) begin
      w_col_eff  = '0;
      w_line_eff = '0;
      w_fill_eff = '0;
    end else begin
      w_col_eff  = r_wr_col;
      w_line_eff = r_wr_line;
      w_fill_eff = r_lines_filled;
    end
    if (w_sof_acc || r_rst_d) begin
      w_width_eff = w_width_clamp;
    end else begin
      w_width_eff = r_width;
    end
    w_eol = ({1'b0, w_col_eff} == (w_width_eff - WID_W'(1)));
    if (w_eol) begin
      w_col_nxt  = '0;
      w_line_nxt = (w_line_eff == LAST_LINE) ? '0 : (w_line_eff + LINE_W'(1));
      w_fill_nxt = (w_fill_eff == FULL_FILL) ? w_fill_eff : (w_fill_eff + FILL_W'(1));
    end else begin
      w_col_nxt  = w_col_eff + ADDR_WIDTH'(1);
      w_line_nxt = w_line_eff;
      w_fill_nxt = w_fill_eff;
    end
`ifdef LWB_ZERO_PAD_EN
    w_emit = 1'b1;
    w_pad  = FULL_FILL - w_fill_eff;
`else
    w_emit = (w_fill_eff == FULL_FILL);
    w_pad  = '0;
`endif
  end

  // Write-column/line counters, priming depth and line width register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_col       <= '0;
      r_wr_line      <= '0;
      r_lines_filled <= '0;
      r_width        <= MAX_WIDTH;
      r_rst_d        <= 1'b1;
    end else begin
      r_rst_d <= 1'b0;
      if (r_rst_d || w_sof_acc) begin
        r_width <= w_width_clamp;
      end
      if (w_acc) begin
        r_wr_col       <= w_col_nxt;
        r_wr_line      <= w_line_nxt;
        r_lines_filled <= w_fill_nxt;
      end
    end
  end

  // Output register: load on accept, clear after handshake, hold on stall
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid   <= 1'b0;
      r_m_col     <= '0;
      r_m_eol     <= 1'b0;
      r_s_data    <= '0;
      r_lane_base <= '0;
      r_pad       <= '0;
    end else if (w_acc) begin
      r_m_valid   <= w_emit;
      r_m_col     <= w_col_eff;
      r_m_eol     <= w_eol;
      r_s_data    <= s_data;
      r_lane_base <= w_line_eff;
      r_pad       <= w_pad;
    end else if (m_ready) begin
      r_m_valid   <= 1'b0;
    end
  end

  // One bank per stored line; the oldest line is overwritten by the live pixel
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    lwb_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .i_rd_en   (w_acc),
      .i_rd_addr (w_col_eff),
      .o_rd_data (w_bank_rd[b]),
      .i_wr_en   (w_acc && (w_line_eff == LINE_W'(b))),
      .i_wr_addr (w_col_eff),
      .i_wr_data (s_data)
    );
  end

  // Rotate bank outputs into age order and apply top-edge padding
  always_comb begin
    logic [LINE_W-1:0] w_idx;
    w_m_data = '0;
    w_idx    = '0;
    for (int j = 0; j < NUM_BANKS; j++) begin
      w_idx = LINE_W'(lwb_rot_idx(int'(r_lane_base), j, NUM_BANKS));
      if (j < int'(r_pad)) begin
        w_m_data[j*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else begin
        w_m_data[j*DATA_WIDTH +: DATA_WIDTH] = w_bank_rd[w_idx];
      end
    end
    w_m_data[NUM_BANKS*DATA_WIDTH +: DATA_WIDTH] = r_s_data;
  end

  assign m_valid = r_m_valid;
  assign m_data  = w_m_data;
  assign m_col   = r_m_col;
  assign m_eol   = r_m_eol;

endmodule

// File: tb/tb_line_window_buffer.sv
// tb_line_window_buffer: randomized stimulus against a frame-level model
// (pixels kept by row/column; a beat for pixel (r,c) is rows r-2..r at c).
module tb_line_window_buffer;

  localparam int K  = 3;
  localparam int DW = 16;
  localparam int AW = 10;
`ifdef LWB_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  typedef struct packed {
    logic [K*DW-1:0] data;
    logic [AW-1:0]   col;
    logic            eol;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [AW:0]     img_width = 11'd4;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic            s_sof = 1'b0;
  logic [DW-1:0]   s_data = 16'd0;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [K*DW-1:0] m_data;
  logic [AW-1:0]   m_col;
  logic            m_eol;

  line_window_buffer #(.NUM_LINES(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .img_width(img_width),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_col(m_col), .m_eol(m_eol)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mr_mode = 0;
  int stall_lo = 0;
  int stall_cnt = 0;

  // Model state
  logic [DW-1:0] pix [0:15][0:1023];
  int  mdl_row = 0, mdl_col = 0, mdl_width = 1024;
  bit  rst_pend = 1'b1;
  beat_t exp_q[$];
  beat_t obs_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int clampw(input int w);
    if (w == 0 || w > 1024) return 1024;
    else return w;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input logic sof);
    beat_t b;
    int r;
    if (sof) begin
      mdl_row = 0; mdl_col = 0; mdl_width = clampw(int'(img_width));
    end
    pix[mdl_row % 16][mdl_col] = d;
    if (mdl_row >= K - 1 || ZP) begin
      b.data = '0;
      for (int j = 0; j < K; j++) begin
        r = mdl_row - (K - 1) + j;
        b.data[j*DW +: DW] = (r < 0) ? 16'd0 : pix[r % 16][mdl_col];
      end
      b.col = AW'(mdl_col);
      b.eol = (mdl_col == mdl_width - 1);
      exp_q.push_back(b);
    end
    mdl_col++;
    if (mdl_col == mdl_width) begin
      mdl_col = 0;
      mdl_row++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: outputs sampled on the falling edge
  initial begin
    beat_t b, a;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        mdl_row = 0; mdl_col = 0; rst_pend = 1'b1;
        chk("ready_in_reset", 64'(s_ready), 64'd0);
      end else begin
        if (rst_pend) begin
          mdl_width = clampw(int'(img_width));
          rst_pend = 1'b0;
          chk("reset_m_valid", 64'(m_valid), 64'd0);
          chk("reset_m_data", 64'(m_data), 64'd0);
          chk("reset_m_col", 64'(m_col), 64'd0);
          chk("reset_m_eol", 64'(m_eol), 64'd0);
        end
        chk("ready_rule", 64'(s_ready), 64'(!m_valid || m_ready));
        if (m_valid && !m_ready) stall_cnt++;
        if (exp_q.size() > 0) begin
          chk("beat_valid", 64'(m_valid), 64'd1);
          if (m_valid) begin
            b = exp_q[0];
            chk("beat_data", 64'(m_data), 64'(b.data));
            chk("beat_col", 64'(m_col), 64'(b.col));
            chk("beat_eol", 64'(m_eol), 64'(b.eol));
            if (m_ready) begin
              a.data = m_data; a.col = m_col; a.eol = m_eol;
              obs_q.push_back(a);
              void'(exp_q.pop_front());
            end
          end
        end else begin
          chk("no_beat", 64'(m_valid), 64'd0);
        end
        if (s_valid && s_ready) model_accept(s_data, s_sof);
      end
    end
  end

  task automatic set_mready();
    case (mr_mode)
      0: m_ready = 1'b1;
      1: m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = !(cyc >= stall_lo && cyc < stall_lo + 5);
    endcase
  endtask

  task automatic send_pix(input logic [DW-1:0] d, input logic sof);
    bit done;
    int budget;
    done = 1'b0; budget = 0;
    if (mr_mode == 1 && $urandom_range(0, 3) == 0) begin
      s_valid = 1'b0; set_mready();
      @(posedge clk); #1;
    end
    while (!done) begin
      s_valid = 1'b1; s_data = d; s_sof = sof; set_mready();
      @(negedge clk);
      done = s_ready;
      @(posedge clk); #1;
      budget++;
      if (!done && budget > 200) begin
        n_chk++; n_fail++;
        $display("FAIL accept_timeout: actual no accept required accept within 200 cycles");
        done = 1'b1;
      end
    end
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic send_rows(input int r0, input int r1, input int width, input bit sof, input bit pat);
    for (int r = r0; r < r1; r++) begin
      for (int c = 0; c < width; c++) begin
        send_pix(pat ? DW'(r * 16 + c) : DW'($urandom), sof && r == r0 && c == 0);
      end
    end
  endtask

  task automatic drain();
    int t;
    s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b1; t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_timeout", 64'(t < 100), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    s_valid = 1'b0; s_sof = 1'b0; reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int off;
    int st0;
    do_reset(3);

    // Basic window and rotation, width 4, continuous flow
    mr_mode = 0; img_width = 11'd4; obs_q.delete();
    send_rows(0, 5, 4, 1'b1, 1'b1);
    drain();
    off = ZP ? 8 : 0;
    chk("basic_count", 64'(obs_q.size()), 64'(ZP ? 20 : 12));
    if (obs_q.size() >= off + 12) begin
      chk("basic_r2c0", 64'(obs_q[off].data), 64'h0020_0010_0000);
      chk("basic_eol_c2", 64'(obs_q[off+2].eol), 64'd0);
      chk("basic_eol_c3", 64'(obs_q[off+3].eol), 64'd1);
      chk("rot_r4c1", 64'(obs_q[off+9].data), 64'h0041_0031_0021);
      chk("rot_r4c1_col", 64'(obs_q[off+9].col), 64'd1);
    end
    if (ZP && obs_q.size() >= 7) begin
      chk("zp_r0c0", 64'(obs_q[0].data), 64'h0000_0000_0000);
      chk("zp_r1c2", 64'(obs_q[6].data), 64'h0012_0002_0000);
    end

    // Backpressure: five stalled cycles in the middle of row 2
    obs_q.delete();
    send_rows(0, 2, 4, 1'b1, 1'b1);
    send_pix(16'h0020, 1'b0);
    mr_mode = 2; stall_lo = cyc + 1; st0 = stall_cnt;
    for (int c = 1; c < 4; c++) send_pix(DW'(16'h20 + c), 1'b0);
    send_rows(3, 4, 4, 1'b0, 1'b1);
    drain();
    chk("bp_stall_cycles", 64'(stall_cnt - st0), 64'd5);
    chk("bp_count", 64'(obs_q.size()), 64'(ZP ? 16 : 8));

    // Mid-frame s_sof at row 3 col 2, random ready
    mr_mode = 1;
    send_rows(0, 3, 4, 1'b1, 1'b1);
    send_pix(16'h0030, 1'b0);
    send_pix(16'h0031, 1'b0);
    drain(); obs_q.delete();
    send_rows(0, 4, 4, 1'b1, 1'b0);
    drain();
    chk("sof_count", 64'(obs_q.size()), 64'(ZP ? 16 : 8));

    // Width 1: every beat ends a line
    img_width = 11'd1; obs_q.delete();
    send_rows(0, 8, 1, 1'b1, 1'b1);
    drain();
    chk("w1_count", 64'(obs_q.size()), 64'(ZP ? 8 : 6));
    if (obs_q.size() >= 3) chk("w1_first", 64'(obs_q[ZP ? 2 : 0].data), 64'h0020_0010_0000);

    // Width 0 and width above the bank size both mean 1024
    mr_mode = 0; img_width = 11'd0; obs_q.delete();
    send_rows(0, 3, 1024, 1'b1, 1'b0);
    drain();
    chk("w0_count", 64'(obs_q.size()), 64'(ZP ? 3072 : 1024));
    if (obs_q.size() > 0) begin
      chk("w0_last_col", 64'(obs_q[obs_q.size()-1].col), 64'd1023);
      chk("w0_last_eol", 64'(obs_q[obs_q.size()-1].eol), 64'd1);
    end
    img_width = 11'd1500; obs_q.delete();
    send_rows(0, 3, 1024, 1'b1, 1'b0);
    drain();
    chk("wbig_count", 64'(obs_q.size()), 64'(ZP ? 3072 : 1024));

    // Reset in the middle of row 2, then re-prime without s_sof
    img_width = 11'd4;
    send_rows(0, 2, 4, 1'b1, 1'b1);
    send_pix(16'h0020, 1'b0);
    send_pix(16'h0021, 1'b0);
    do_reset(1);
    obs_q.delete(); mr_mode = 1;
    send_rows(0, 3, 4, 1'b0, 1'b0);
    drain();
    chk("rst_reprime_count", 64'(obs_q.size()), 64'(ZP ? 12 : 4));

    // Random soak over small widths
    for (int f = 0; f < 6; f++) begin
      int w;
      w = int'($urandom_range(1, 6));
      img_width = 11'(w);
      send_rows(0, int'($urandom_range(3, 5)), w, 1'b1, 1'b0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
